// File: rtl/lpf_integrate_dump.sv
// Multi-channel integrate-and-dump low-pass filter: power-of-two windows,
// round-half-up averaging, output clamping and symbol-sync realignment.
module lpf_integrate_dump #(
    parameter int NUM_CH       = 2,
    parameter int DATA_WIDTH   = 18,
    parameter int LOG2_MAX_LEN = 6,
    parameter int OUT_WIDTH    = 18
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic signed [DATA_WIDTH-1:0]         in_data [0:NUM_CH-1],
    input  logic [$clog2(LOG2_MAX_LEN+1)-1:0]    len_log2,
    input  logic                                 sync,
    output logic                                 out_valid,
    output logic signed [OUT_WIDTH-1:0]          out_data [0:NUM_CH-1],
    output logic [NUM_CH-1:0]                    out_sat
);

    localparam int LW    = $clog2(LOG2_MAX_LEN + 1);
    localparam int ACC_W = DATA_WIDTH + LOG2_MAX_LEN;
    localparam int CNT_W = LOG2_MAX_LEN;

    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic {EMPTY, FILL} state_t;

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt, w_cnt_eff, w_last_idx;
    logic [LW-1:0]            r_nl, w_nl, w_nl_nxt;
    logic signed [ACC_W-1:0]  r_acc     [0:NUM_CH-1];
    logic signed [ACC_W-1:0]  w_acc_nxt [0:NUM_CH-1];
    logic signed [ACC_W-1:0]  w_sum     [0:NUM_CH-1];
    logic signed [ACC_W:0]    w_rnd     [0:NUM_CH-1];
    logic signed [OUT_WIDTH-1:0] w_res  [0:NUM_CH-1];
    logic [NUM_CH-1:0]        w_sat;
    logic [ACC_W:0]           w_half;
    logic                     w_start;
    logic                     w_dump;

    always_comb begin
        // sync collapses the partial window first, so this cycle's sample
        // is treated exactly as if the block were EMPTY.
        w_start    = sync || (r_state == EMPTY);
        w_nl       = r_nl;
        if (w_start) begin
            w_nl = (len_log2 > LW'(LOG2_MAX_LEN)) ? LW'(LOG2_MAX_LEN) : len_log2;
        end
        w_cnt_eff  = w_start ? '0 : r_cnt;
        w_last_idx = {CNT_W{1'b1}} >> (CNT_W - int'(w_nl));
        w_dump     = in_valid && (w_cnt_eff == w_last_idx);
        w_half     = ({{ACC_W{1'b0}}, 1'b1} << w_nl) >> 1;

        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_sum[ch] = (w_start ? '0 : r_acc[ch]) + ACC_W'(in_data[ch]);
            w_rnd[ch] = ((ACC_W + 1)'(w_sum[ch]) + $signed(w_half)) >>> w_nl;
            w_sat[ch] = 1'b0;
            if (w_rnd[ch] > MAXV) begin
                w_res[ch] = MAXV[OUT_WIDTH-1:0];
                w_sat[ch] = 1'b1;
            end else if (w_rnd[ch] < MINV) begin
                w_res[ch] = MINV[OUT_WIDTH-1:0];
                w_sat[ch] = 1'b1;
            end else begin
                w_res[ch] = w_rnd[ch][OUT_WIDTH-1:0];
            end
        end

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nl_nxt    = r_nl;
        w_acc_nxt   = r_acc;
        if (in_valid) begin
            w_nl_nxt = w_nl;
            if (w_dump) begin
                w_state_nxt = EMPTY;
                w_cnt_nxt   = '0;
                for (int unsigned ch = 0; ch < NUM_CH; ch++) w_acc_nxt[ch] = '0;
            end else begin
                w_state_nxt = FILL;
                w_cnt_nxt   = w_cnt_eff + 1'b1;
                w_acc_nxt   = w_sum;
            end
        end else if (sync) begin
            w_state_nxt = EMPTY;
            w_cnt_nxt   = '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) w_acc_nxt[ch] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= EMPTY;
            r_cnt     <= '0;
            r_nl      <= '0;
            out_valid <= 1'b0;
            out_sat   <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_acc[ch]    <= '0;
                out_data[ch] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_nl      <= w_nl_nxt;
            r_acc     <= w_acc_nxt;
            out_valid <= w_dump;
            if (w_dump) begin
                out_data <= w_res;
                out_sat  <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_lpf_integrate_dump.sv
// Directed scoreboard bench for lpf_integrate_dump: an 18-bit-output and a
// 12-bit-output instance share stimulus; expected averages are hand-derived.
module tb_lpf_integrate_dump;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [17:0] in_data [0:1];
    logic [2:0]         len_log2;
    logic               sync;

    logic               w_valid;
    logic signed [17:0] w_data [0:1];
    logic [1:0]         w_sat;
    logic               n_valid;
    logic signed [11:0] n_data [0:1];
    logic [1:0]         n_sat;

    typedef struct {
        logic signed [31:0] d0;
        logic signed [31:0] d1;
        logic [1:0]         sat;
    } exp_t;

    exp_t q_w[$];
    exp_t q_n[$];
    int   tests;
    int   fails;

    lpf_integrate_dump #(.NUM_CH(2), .DATA_WIDTH(18), .LOG2_MAX_LEN(6), .OUT_WIDTH(18)) u_wide (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .len_log2(len_log2), .sync(sync),
        .out_valid(w_valid), .out_data(w_data), .out_sat(w_sat)
    );

    lpf_integrate_dump #(.NUM_CH(2), .DATA_WIDTH(18), .LOG2_MAX_LEN(6), .OUT_WIDTH(12)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .len_log2(len_log2), .sync(sync),
        .out_valid(n_valid), .out_data(n_data), .out_sat(n_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] clampv(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Push the expected result for both instances given the exact averages.
    task automatic expect_out(input int a0, input int a1);
        exp_t e;
        e.d0  = clampv(a0, 18);
        e.d1  = clampv(a1, 18);
        e.sat = {(e.d1 != a1), (e.d0 != a0)};
        q_w.push_back(e);
        e.d0  = clampv(a0, 12);
        e.d1  = clampv(a1, 12);
        e.sat = {(e.d1 != a1), (e.d0 != a0)};
        q_n.push_back(e);
    endtask

    task automatic step(input logic v, input int s0, input int s1,
                        input int len, input logic sy);
        in_valid   = v;
        in_data[0] = s0[17:0];
        in_data[1] = s1[17:0];
        len_log2   = len[2:0];
        sync       = sy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && w_valid) begin
            if (q_w.size() == 0) begin
                check("wide_spurious_pulse", w_valid, 0);
            end else begin
                exp_t e;
                e = q_w.pop_front();
                check("wide_ch0", w_data[0], e.d0);
                check("wide_ch1", w_data[1], e.d1);
                check("wide_sat", w_sat, e.sat);
            end
        end
        if (rst && n_valid) begin
            if (q_n.size() == 0) begin
                check("narrow_spurious_pulse", n_valid, 0);
            end else begin
                exp_t e;
                e = q_n.pop_front();
                check("narrow_ch0", n_data[0], e.d0);
                check("narrow_ch1", n_data[1], e.d1);
                check("narrow_sat", n_sat, e.sat);
            end
        end
    end

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data[0] = '0;
        in_data[1] = '0;
        len_log2   = '0;
        sync       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", w_valid, 0);
        check("reset_data0", w_data[0], 0);
        check("reset_sat", w_sat, 0);
        check("reset_narrow_valid", n_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Ramp: sums +/-28672, averages round to +/-3584 (narrow clamps).
        for (int i = 0; i < 8; i++) begin
            if (i == 7) expect_out(3584, -3584);
            step(1'b1, i * 1024, -i * 1024, 3, 1'b0);
        end
        step(1'b0, 0, 0, 3, 1'b0);
        step(1'b0, 0, 0, 3, 1'b0);

        // Asynchronous reset in the middle of a window.
        for (int i = 0; i < 3; i++) step(1'b1, 500, -500, 3, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_valid", w_valid, 0);
        check("midreset_wide_data0", w_data[0], 0);
        check("midreset_wide_data1", w_data[1], 0);
        check("midreset_narrow_data0", n_data[0], 0);
        check("midreset_narrow_sat", n_sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) expect_out(1024, -1024);
            step(1'b1, 1024, -1024, 3, 1'b0);
        end

        // Rounding: (1+2+1)>>1 = 2, (-3+1)>>>1 = -1.
        step(1'b1, 1, -1, 1, 1'b0);
        expect_out(2, -1);
        step(1'b1, 2, -2, 1, 1'b0);

        // Pass-through with a single-sample window: back-to-back pulses.
        expect_out(5, -5);
        step(1'b1, 5, -5, 0, 1'b0);
        expect_out(-7, 7);
        step(1'b1, -7, 7, 0, 1'b0);
        expect_out(9, -9);
        step(1'b1, 9, -9, 0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);

        // Full-scale inputs: narrow instance clamps to 2047 / -2048.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expect_out(131071, -131072);
            step(1'b1, 131071, -131072, 2, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expect_out(-131072, 131071);
            step(1'b1, -131072, 131071, 2, 1'b0);
        end

        // sync drops the 100,100 partial window; new window of 8s with gaps.
        step(1'b1, 100, -100, 2, 1'b0);
        step(1'b1, 100, -100, 2, 1'b0);
        expect_out(8, -8);
        step(1'b1, 8, -8, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 0, 2, 1'b0);
            step(1'b0, 0, 0, 2, 1'b0);
            step(1'b1, 8, -8, 2, 1'b0);
        end

        // Length change mid-window: still 4 samples, (100+2)>>2 = 25.
        expect_out(25, -25);
        step(1'b1, 10, -10, 2, 1'b0);
        step(1'b1, 20, -20, 0, 1'b0);
        step(1'b1, 30, -30, 0, 1'b0);
        step(1'b1, 40, -40, 0, 1'b0);
        expect_out(7, -7);
        step(1'b1, 7, -7, 0, 1'b0);

        repeat (3) step(1'b0, 0, 0, 0, 1'b0);
        check("hold_valid_low", w_valid, 0);
        check("hold_wide_data0", w_data[0], 7);
        check("hold_narrow_data1", n_data[1], -7);
        check("wide_missing_pulses", q_w.size(), 0);
        check("narrow_missing_pulses", q_n.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lpf_integrate_dump.md
# lpf_integrate_dump

Parametrised multi-channel integrate-and-dump low-pass filter for the BPSK receive path, placed after the mixer/downconverter and ahead of symbol decision. It supersedes the fixed-size array integrator with a streaming, valid-qualified input, runtime-selectable power-of-two window length, symbol-sync realignment, rounding and output saturation. All channels (I/Q by default) share one window counter and are integrated in lockstep.

## Interface
- NUM_CH, 2, number of parallel channels
- DATA_WIDTH, 18, signed input sample width
- LOG2_MAX_LEN, 6, log2 of the maximum window length (max 64 samples)
- OUT_WIDTH, 18, signed output width; results are clamped to this range

- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset; low clears all state immediately
- in_valid  in  1  in_data qualifier, one sample per channel per asserted cycle
- in_data  in  [0:NUM_CH-1][DATA_WIDTH-1:0]  signed samples, unpacked array indexed by channel
- len_log2  in  $clog2(LOG2_MAX_LEN+1)  window length exponent N, window = 2^N samples
- sync  in  1  symbol-boundary strobe; discards the partial window
- out_valid  out  1  one-cycle pulse per completed window
- out_data  out  [0:NUM_CH-1][OUT_WIDTH-1:0]  signed window averages
- out_sat  out  [NUM_CH-1:0]  per-channel saturation flag, valid with out_valid

## Operation
- Accumulator per channel, ACC_W = DATA_WIDTH + LOG2_MAX_LEN bits signed; inputs sign-extended. Cannot overflow.
- Shared counter cnt, 0..2^LOG2_MAX_LEN-1. Latched length Nl.
- FSM states: EMPTY (cnt==0, no partial sum), FILL (partial window held).
- EMPTY + in_valid: latch Nl = min(len_log2, LOG2_MAX_LEN). If Nl==0, dump immediately. Otherwise acc = sample, cnt = 1, go to FILL.
- FILL + in_valid: sum = acc + sample. If cnt == 2^Nl-1, dump and go to EMPTY. Otherwise acc = sum, cnt++.
- in_valid low: state, acc and cnt hold. Gaps of any length are allowed.
- Dump:
  - r = (sum + (Nl>0 ? 2^(Nl-1) : 0)) >>> Nl, arithmetic shift (round half toward +inf).
  - Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat[ch] = 1 iff clamped.
  - Register out_data and out_sat; pulse out_valid; clear acc and cnt.
- len_log2 is sampled only at window start. Changes during FILL take effect on the next window.
- sync high: the partial window is dropped with no output, and the block returns to EMPTY before this cycle's sample is processed. A concurrent in_valid sample therefore starts the new window, using the len_log2 present that cycle.
- sync while EMPTY: no effect beyond the above.
- out_data and out_sat hold their last values between pulses.

## Timing
- Reset values: out_valid=0, out_data=0 for all channels, out_sat=0, acc=0, cnt=0, state EMPTY, Nl=0.
- Latency: out_valid rises on the clock edge that captures the window's final sample, so it is visible the cycle after that sample is presented. Pulse width is exactly one cycle.
- Throughput: one sample per cycle sustained. Back-to-back windows produce no bubble, and with Nl=0 out_valid can be high every cycle.
- rst asserted mid-window: all state and outputs go to reset values asynchronously. After deassertion the next in_valid sample starts a fresh window.
- Final sample coincident with sync: sync wins. No dump occurs, and the sample starts a new window.

## Test plan
- Reset: feed 3 samples with len_log2=3, then drive rst low. Outputs go to 0 immediately. After release, 8 samples of 1024 -> out_data=1024, one out_valid pulse.
- Ramp average: len_log2=3, NUM_CH=2, ch0 = i*1024 and ch1 = -i*1024 for i=0..7, consecutive cycles -> one cycle after i=7, out_valid=1, ch0=3584, ch1=-3584, out_sat=0.
- Rounding and pass-through:
  - len_log2=1, samples 1,2 -> 2; samples -1,-2 -> -1.
  - len_log2=0, samples 5,-7,9 -> outputs 5,-7,9 on three consecutive pulses.
- Saturation (OUT_WIDTH=12 instance):
  - len_log2=2, four samples of 131071 -> out_data=2047, out_sat=1.
  - four samples of -131072 -> -2048, out_sat=1.
- sync and gaps: len_log2=2, samples 100,100, then sync together with sample 8, then 8,8,8 with 2-cycle in_valid gaps -> exactly one pulse, out_data=8. No output from the dropped window.
- Length change mid-window: len_log2=2 at start, switch to 0 after 1 sample -> the window still closes after 4 samples. The next sample dumps alone.
